enc_sequencer: RTL and testbench
================================

ENC_SEQUENCER -- requirements
Module: enc_sequencer

Interface
REQ-001 SHALL have parameter SCRAMBLER_SEED, default 7'b1011101: initial scrambler state (x7..x1); used only when SCRAMBLER_EN is defined.
REQ-002 SHALL have port Clock  input  1  encoder-rate clock (2x bit rate), all logic on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  frame start request, sampled only in IDLE.
REQ-005 SHALL have port Rate  input  4  802.11a RATE code, sampled with Start.
REQ-006 SHALL have port Length  input  12  PSDU length in bytes, sampled with Start.
REQ-007 SHALL have port DataIn  input  8  PSDU byte, sent LSB first.
REQ-008 SHALL have port DataValid  input  1  DataIn valid.
REQ-009 SHALL have port DataReady  output  1  one-byte buffer empty; byte transfers on a clock edge where DataValid and DataReady are both high.
REQ-010 SHALL have port BitOut  output  1  serial bit to convolutional encoder Input.
REQ-011 SHALL have port EncReset  output  1  drives encoder Reset; high while no frame is active.
REQ-012 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port Done  output  1  one-cycle pulse on normal frame completion.
REQ-014 SHALL have port Error  output  1  one-cycle pulse on rejected Start or data underrun.

Function
REQ-015 SHALL implement states IDLE, SERVICE, DATA, TAIL, PAD.
REQ-016 SHALL map Rate to N_DBPS as follows: 1101->24, 1111->36, 0101->48, 0111->72, 1001->96, 1011->144, 0001->192, 0011->216.
REQ-017 SHALL, on Start in IDLE with an unmapped Rate or Length==0, pulse Error and stay in IDLE.
REQ-018 SHALL, on a valid Start in IDLE, latch Rate and Length, enter SERVICE, and deassert EncReset from the next cycle.
REQ-019 SHALL hold each bit on BitOut for exactly 2 clocks; bit k occupies cycles 2k and 2k+1 after Start acceptance.
REQ-020 SHALL emit the bit sequence 16 SERVICE zeros, then 8*Length PSDU bits, then 6 TAIL zeros, then PAD zeros.
REQ-021 SHALL size PAD so that the total bit count equals ceil((22+8*Length)/N_DBPS)*N_DBPS; PAD may be 0, in which case TAIL goes directly to IDLE.
REQ-022 SHALL compute the symbol count with a counter (no divider), supporting Length up to 4095.
REQ-023 SHALL assert DataReady whenever the byte buffer is empty and state is SERVICE or DATA; DataReady SHALL be 0 in IDLE, TAIL and PAD, and after the last PSDU byte is accepted.
REQ-024 SHALL, if the buffer is empty when the next PSDU bit is due, pulse Error, return to IDLE and reassert EncReset the next cycle (abort; no Done).
REQ-025 SHALL, after the second clock of the final bit, return to IDLE, pulse Done, and reassert EncReset.
REQ-026 SHALL ignore Start while Busy.
REQ-027 SHALL NOT assert Done and Error in the same cycle.

Reset
REQ-028 SHALL, on Reset (any time, including mid-frame), immediately force state IDLE, BitOut=0, EncReset=1, Busy=0, Done=0, Error=0, DataReady=0, buffer empty, all counters to 0, and scrambler state to SCRAMBLER_SEED.

Configuration
REQ-029 SHALL, with SCRAMBLER_EN defined, XOR every SERVICE, DATA and PAD bit with the output of the x^7+x^4+1 scrambler (loaded from SCRAMBLER_SEED at Start acceptance, advanced once per bit), and SHALL force TAIL bits to 0 unscrambled.
REQ-030 SHALL, without SCRAMBLER_EN, emit all bits unscrambled and contain no scrambler logic; SCRAMBLER_SEED is then unused.

Verification
REQ-031 SHALL cover: Rate=1101, Length=1, byte 8'hA5 always valid -> 48 bits (16 zeros, 1,0,1,0,0,1,0,1, 6 zeros, 18 zeros); Done pulses 96 clocks after Start acceptance.
REQ-032 SHALL cover: Rate=0011, Length=100 -> 864 bits total (PAD=42); Busy high for 1728 cycles.
REQ-033 SHALL cover: Rate=1010 with Start -> Error pulse, Busy stays 0, EncReset stays 1; Length=0 gives the same result.
REQ-034 SHALL cover: DataValid held low after the first byte of Length=4 -> Error pulse at bit 24, return to IDLE, no Done.
REQ-035 SHALL cover: Reset asserted mid-DATA -> all outputs at reset values in the same cycle, and a subsequent frame completes correctly.
REQ-036 SHALL cover, with SCRAMBLER_EN and SCRAMBLER_SEED=7'b1111111: first 8 SERVICE bits 0,0,0,0,1,1,1,0; the 6 TAIL bits are all 0.

Source files
------------

// File: rtl/enc_sequencer.sv
// 802.11a DATA-field bit sequencer (SERVICE, PSDU, TAIL, PAD) feeding a rate-1/2 convolutional encoder.
// Optional x^7+x^4+1 scrambler is compiled in when SCRAMBLER_EN is defined.
module enc_sequencer #(
    parameter logic [6:0] SCRAMBLER_SEED = 7'b1011101
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  Rate,
    input  logic [11:0] Length,
    input  logic [7:0]  DataIn,
    input  logic        DataValid,
    output logic        DataReady,
    output logic        BitOut,
    output logic        EncReset,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {S_IDLE, S_SERVICE, S_DATA, S_TAIL, S_PAD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_phase;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [11:0] r_bytes_left;
    logic [11:0] r_accept_left;
    logic [7:0]  r_ndbps;
    logic [7:0]  r_sym_pos;
    logic        r_buf_full;
    logic [7:0]  r_buf;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_bitout;
    logic        r_done;
    logic        r_error;
    logic [7:0]  w_ndbps_in;
    logic        w_start;
    logic        w_step;
    logic        w_load_byte;
    logic        w_byte_due;
    logic        w_bit_raw;
    logic        w_bit_final;
    logic        w_done;
    logic        w_error;
    logic        w_sym_wrap;
    logic        w_xfer;

    function automatic logic [7:0] f_ndbps(input logic [3:0] rate);
        case (rate)
            4'b1101: f_ndbps = 8'd24;
            4'b1111: f_ndbps = 8'd36;
            4'b0101: f_ndbps = 8'd48;
            4'b0111: f_ndbps = 8'd72;
            4'b1001: f_ndbps = 8'd96;
            4'b1011: f_ndbps = 8'd144;
            4'b0001: f_ndbps = 8'd192;
            4'b0011: f_ndbps = 8'd216;
            default: f_ndbps = 8'd0;
        endcase
    endfunction

    assign w_ndbps_in = f_ndbps(Rate);
    assign w_step     = r_phase && (r_state != S_IDLE);
    // Bit position inside the current OFDM symbol; wrapping after TAIL marks the frame end.
    assign w_sym_wrap = (r_sym_pos == (r_ndbps - 8'd1));
    assign w_byte_due = ((r_state == S_SERVICE) && (r_cnt == 4'd15)) ||
                        ((r_state == S_DATA) && (r_cnt == 4'd7) && (r_bytes_left != 12'd0));
    assign DataReady  = ((r_state == S_SERVICE) || (r_state == S_DATA)) &&
                        !r_buf_full && (r_accept_left != 12'd0);
    assign w_xfer     = DataValid && DataReady;

    assign BitOut   = r_bitout;
    assign EncReset = (r_state == S_IDLE);
    assign Busy     = (r_state != S_IDLE);
    assign Done     = r_done;
    assign Error    = r_error;

`ifdef SCRAMBLER_EN
    logic [6:0] r_scr;
    logic [6:0] w_scr_cur;
    logic       w_scr_bit;

    assign w_scr_cur   = w_start ? SCRAMBLER_SEED : r_scr;
    assign w_scr_bit   = w_scr_cur[6] ^ w_scr_cur[3];
    assign w_bit_final = w_bit_raw ^ (w_scr_bit & (w_state_nxt != S_TAIL));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_scr <= SCRAMBLER_SEED;
        end else if (w_start || w_step) begin
            r_scr <= {w_scr_cur[5:0], w_scr_bit};
        end
    end
`else
    assign w_bit_final = w_bit_raw;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_bit_raw   = 1'b0;
        w_load_byte = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if ((w_ndbps_in == 8'd0) || (Length == 12'd0)) begin
                        w_error = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = S_SERVICE;
                    end
                end
            end
            S_SERVICE, S_DATA: begin
                if (r_phase) begin
                    if (w_byte_due) begin
                        if (r_buf_full) begin
                            w_state_nxt = S_DATA;
                            w_cnt_nxt   = 4'd0;
                            w_load_byte = 1'b1;
                            w_shift_nxt = r_buf;
                            w_bit_raw   = r_buf[0];
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_error     = 1'b1;
                        end
                    end else if (r_state == S_SERVICE) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (r_cnt != 4'd7) begin
                        w_cnt_nxt   = r_cnt + 4'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_raw   = r_shift[1];
                    end else begin
                        w_state_nxt = S_TAIL;
                        w_cnt_nxt   = 4'd0;
                    end
                end
            end
            S_TAIL: begin
                if (r_phase) begin
                    if (r_cnt != 4'd5) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_sym_wrap) begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (r_phase && w_sym_wrap) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_phase       <= 1'b0;
            r_cnt         <= 4'd0;
            r_bytes_left  <= 12'd0;
            r_accept_left <= 12'd0;
            r_ndbps       <= 8'd0;
            r_sym_pos     <= 8'd0;
            r_buf_full    <= 1'b0;
            r_bitout      <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done;
            r_error <= w_error;
            if (w_state_nxt == S_IDLE) begin
                r_phase       <= 1'b0;
                r_cnt         <= 4'd0;
                r_bytes_left  <= 12'd0;
                r_accept_left <= 12'd0;
                r_sym_pos     <= 8'd0;
                r_buf_full    <= 1'b0;
                r_bitout      <= 1'b0;
            end else if (w_start) begin
                r_phase       <= 1'b0;
                r_cnt         <= 4'd0;
                r_bytes_left  <= Length;
                r_accept_left <= Length;
                r_ndbps       <= w_ndbps_in;
                r_sym_pos     <= 8'd0;
                r_buf_full    <= 1'b0;
                r_bitout      <= w_bit_final;
            end else begin
                r_phase <= ~r_phase;
                if (w_step) begin
                    r_cnt     <= w_cnt_nxt;
                    r_bitout  <= w_bit_final;
                    r_sym_pos <= w_sym_wrap ? 8'd0 : (r_sym_pos + 8'd1);
                    if (w_load_byte) begin
                        r_bytes_left <= r_bytes_left - 12'd1;
                    end
                end
                // Fill and drain of the one-byte buffer are mutually exclusive via DataReady.
                if (w_load_byte) begin
                    r_buf_full <= 1'b0;
                end else if (w_xfer) begin
                    r_buf_full    <= 1'b1;
                    r_accept_left <= r_accept_left - 12'd1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (w_xfer) begin
            r_buf <= DataIn;
        end
        if (w_step) begin
            r_shift <= w_shift_nxt;
        end
    end

endmodule

// File: tb/tb_enc_sequencer.sv
// Directed self-checking bench for enc_sequencer (frame timing, bit content, rejects, underrun, reset).
`timescale 1ns/1ps
module tb_enc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic [7:0]  DataIn;
    logic        DataValid;
    logic        DataReady;
    logic        BitOut;
    logic        EncReset;
    logic        Busy;
    logic        Done;
    logic        Error;

    enc_sequencer #(.SCRAMBLER_SEED(7'b1111111)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate), .Length(Length),
        .DataIn(DataIn), .DataValid(DataValid), .DataReady(DataReady), .BitOut(BitOut),
        .EncReset(EncReset), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    logic [7:0] feed [0:127];
    int feed_n;
    int feed_idx;
    logic cap[$];
    logic exp_q[$];
    logic exp_tail[$];
    int done_at, err_at, end_at, hold_err, busy_cnt, encrst_err, poke_at;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic update_feed();
        DataValid = (feed_idx < feed_n);
        DataIn    = (feed_idx < feed_n) ? feed[feed_idx] : 8'h00;
    endtask

    task automatic start_frame(input logic [3:0] r, input logic [11:0] l);
        Rate = r; Length = l; Start = 1'b1;
        feed_idx = 0;
        update_feed();
        tick();
        Start = 1'b0;
    endtask

    task automatic run_frame(input int max_cyc);
        logic xfer;
        cap.delete();
        done_at = -1; err_at = -1; end_at = -1;
        hold_err = 0; busy_cnt = 0; encrst_err = 0;
        for (int c = 0; c <= max_cyc; c++) begin
            if (Done && done_at < 0) done_at = c;
            if (Error && err_at < 0) err_at = c;
            if (!Busy) begin
                end_at = c;
                break;
            end
            busy_cnt++;
            if (EncReset) encrst_err++;
            if (c % 2 == 0) cap.push_back(BitOut);
            else if (BitOut !== cap[$]) hold_err++;
            if (c == poke_at) begin
                Start = 1'b1; Rate = 4'b1010; Length = 12'd0;
            end else begin
                Start = 1'b0;
            end
            xfer = DataValid && DataReady;
            tick();
            if (xfer) begin
                feed_idx++;
                update_feed();
            end
        end
        Start = 1'b0;
        poke_at = -1;
    endtask

    task automatic build_expected(input int len, input int ndbps);
        logic [6:0] s;
        logic fb;
        exp_q.delete(); exp_tail.delete();
        for (int k = 0; k < 16; k++) begin exp_q.push_back(1'b0); exp_tail.push_back(1'b0); end
        for (int i = 0; i < len; i++)
            for (int b = 0; b < 8; b++) begin exp_q.push_back(feed[i][b]); exp_tail.push_back(1'b0); end
        for (int k = 0; k < 6; k++) begin exp_q.push_back(1'b0); exp_tail.push_back(1'b1); end
        while (exp_q.size() % ndbps != 0) begin exp_q.push_back(1'b0); exp_tail.push_back(1'b0); end
        s = 7'b1111111;
        for (int k = 0; k < exp_q.size(); k++) begin
            fb = s[6] ^ s[3];
`ifdef SCRAMBLER_EN
            if (!exp_tail[k]) exp_q[k] = exp_q[k] ^ fb;
`endif
            s = {s[5:0], fb};
        end
    endtask

    function automatic int count_diff(input int n);
        int d = 0;
        for (int k = 0; k < n; k++)
            if (k >= cap.size() || k >= exp_q.size() || cap[k] !== exp_q[k]) d++;
        return d;
    endfunction

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Rate = 4'd0; Length = 12'd0;
        feed_n = 0; feed_idx = 0; update_feed();
        tick(); tick();
        checks++;
        if ({BitOut, EncReset, Busy, Done, Error, DataReady} !== 6'b010000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 010000", {BitOut, EncReset, Busy, Done, Error, DataReady});
        end
        Reset = 1'b0;
        tick(); tick();
        checks++;
        if ({BitOut, EncReset, Busy, Done, Error, DataReady} !== 6'b010000) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected 010000", {BitOut, EncReset, Busy, Done, Error, DataReady});
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] got8;
        feed[0] = 8'hA5; feed_n = 1;
        poke_at = 10;
        start_frame(4'b1101, 12'd1);
        run_frame(300);
        build_expected(1, 24);
        checks++;
        if (cap.size() !== 48) begin errors++; $display("FAIL basic_bitcount: got %0d expected 48", cap.size()); end
        checks++;
        if (count_diff(48) !== 0) begin errors++; $display("FAIL basic_bits: got %0d wrong bits expected 0", count_diff(48)); end
        for (int k = 0; k < 8; k++) got8[7-k] = (cap.size() > 16 + k) ? cap[16+k] : 1'bx;
`ifndef SCRAMBLER_EN
        checks++;
        if (got8 !== 8'b10100101) begin errors++; $display("FAIL basic_psdu: got %b expected 10100101", got8); end
`else
        for (int k = 0; k < 8; k++) got8[7-k] = (cap.size() > k) ? cap[k] : 1'bx;
        checks++;
        if (got8 !== 8'b00001110) begin errors++; $display("FAIL scr_service: got %b expected 00001110", got8); end
        for (int k = 0; k < 6; k++) got8[k] = (cap.size() > 24 + k) ? cap[24+k] : 1'bx;
        checks++;
        if (got8[5:0] !== 6'b000000) begin errors++; $display("FAIL scr_tail: got %b expected 000000", got8[5:0]); end
`endif
        checks++;
        if (done_at !== 96 || end_at !== 96) begin
            errors++; $display("FAIL basic_done_time: got done=%0d idle=%0d expected 96", done_at, end_at);
        end
        checks++;
        if (err_at !== -1) begin errors++; $display("FAIL basic_no_error: got error at %0d expected none", err_at); end
        checks++;
        if (hold_err !== 0 || encrst_err !== 0) begin
            errors++; $display("FAIL basic_hold: got hold=%0d encrst=%0d expected 0", hold_err, encrst_err);
        end
        checks++;
        if (EncReset !== 1'b1) begin errors++; $display("FAIL basic_encreset_end: got %b expected 1", EncReset); end
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", Done, Busy);
        end
    endtask

    task automatic test_rate_table();
        logic [3:0] rates [8];
        int totals [8];
        int ndbps [8];
        rates  = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011};
        ndbps  = '{24, 36, 48, 72, 96, 144, 192, 216};
        totals = '{48, 36, 48, 72, 96, 144, 192, 216};
        feed[0] = 8'h5A; feed_n = 1;
        for (int i = 0; i < 8; i++) begin
            start_frame(rates[i], 12'd1);
            run_frame(1000);
            build_expected(1, ndbps[i]);
            checks++;
            if (cap.size() !== totals[i] || done_at !== 2 * totals[i] || count_diff(totals[i]) !== 0) begin
                errors++;
                $display("FAIL rate_%b: got bits=%0d done=%0d diff=%0d expected bits=%0d done=%0d diff=0",
                         rates[i], cap.size(), done_at, count_diff(totals[i]), totals[i], 2 * totals[i]);
            end
            tick();
        end
    endtask

    task automatic test_long_frame();
        for (int i = 0; i < 100; i++) feed[i] = 8'(i * 37 + 11);
        feed_n = 100;
        start_frame(4'b0011, 12'd100);
        run_frame(4000);
        build_expected(100, 216);
        checks++;
        if (cap.size() !== 864) begin errors++; $display("FAIL long_bitcount: got %0d expected 864", cap.size()); end
        checks++;
        if (busy_cnt !== 1728) begin errors++; $display("FAIL long_busy: got %0d expected 1728", busy_cnt); end
        checks++;
        if (done_at !== 1728) begin errors++; $display("FAIL long_done: got %0d expected 1728", done_at); end
        checks++;
        if (count_diff(864) !== 0) begin errors++; $display("FAIL long_bits: got %0d wrong expected 0", count_diff(864)); end
        tick();
    endtask

    task automatic test_reject();
        logic [3:0]  rr [2];
        logic [11:0] ll [2];
        rr = '{4'b1010, 4'b1101};
        ll = '{12'd5, 12'd0};
        feed_n = 0;
        for (int i = 0; i < 2; i++) begin
            Rate = rr[i]; Length = ll[i]; Start = 1'b1;
            tick();
            Start = 1'b0;
            checks++;
            if ({Error, Busy, EncReset, Done} !== 4'b1010) begin
                errors++; $display("FAIL reject_%0d: got %b expected 1010", i, {Error, Busy, EncReset, Done});
            end
            tick();
            checks++;
            if ({Error, Busy, EncReset} !== 3'b001) begin
                errors++; $display("FAIL reject_after_%0d: got %b expected 001", i, {Error, Busy, EncReset});
            end
        end
    endtask

    task automatic test_underrun();
        feed[0] = 8'h3C; feed_n = 1;
        start_frame(4'b1101, 12'd4);
        run_frame(400);
        build_expected(4, 24);
        checks++;
        if (err_at !== 48 || end_at !== 48) begin
            errors++; $display("FAIL underrun_time: got err=%0d idle=%0d expected 48", err_at, end_at);
        end
        checks++;
        if (done_at !== -1) begin errors++; $display("FAIL underrun_no_done: got done at %0d expected none", done_at); end
        checks++;
        if (cap.size() !== 24 || count_diff(24) !== 0) begin
            errors++; $display("FAIL underrun_bits: got n=%0d diff=%0d expected 24 0", cap.size(), count_diff(24));
        end
        checks++;
        if (EncReset !== 1'b1) begin errors++; $display("FAIL underrun_encreset: got %b expected 1", EncReset); end
        tick();
        checks++;
        if (Error !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL underrun_pulse: got err=%b done=%b expected 0 0", Error, Done);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic xfer;
        for (int i = 0; i < 4; i++) feed[i] = 8'hFF;
        feed_n = 4;
        start_frame(4'b1101, 12'd4);
        for (int c = 0; c < 32; c++) begin
            xfer = DataValid && DataReady;
            tick();
            if (xfer) begin feed_idx++; update_feed(); end
        end
        checks++;
`ifdef SCRAMBLER_EN
        if ({DataReady, Busy} !== 2'b11) begin
            errors++; $display("FAIL mid_pre: got %b expected 11", {DataReady, Busy});
        end
`else
        if ({BitOut, DataReady, Busy} !== 3'b111) begin
            errors++; $display("FAIL mid_pre: got %b expected 111", {BitOut, DataReady, Busy});
        end
`endif
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({BitOut, EncReset, Busy, Done, Error, DataReady} !== 6'b010000) begin
            errors++; $display("FAIL mid_reset: got %b expected 010000", {BitOut, EncReset, Busy, Done, Error, DataReady});
        end
        feed_n = 0; feed_idx = 0; update_feed();
        tick();
        Reset = 1'b0;
        tick();
        feed[0] = 8'h12; feed[1] = 8'h34; feed[2] = 8'h56; feed_n = 3;
        start_frame(4'b0101, 12'd3);
        run_frame(400);
        build_expected(3, 48);
        checks++;
        if (cap.size() !== 48 || count_diff(48) !== 0) begin
            errors++; $display("FAIL after_reset_bits: got n=%0d diff=%0d expected 48 0", cap.size(), count_diff(48));
        end
        checks++;
        if (done_at !== 96 || err_at !== -1) begin
            errors++; $display("FAIL after_reset_done: got done=%0d err=%0d expected 96 -1", done_at, err_at);
        end
        tick();
    endtask

    initial begin
        poke_at = -1;
        Reset = 1'b1;
        tick();
        test_reset();
        test_basic_frame();
        test_rate_table();
        test_long_frame();
        test_reject();
        test_underrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
